// File: rtl/tob_strategy_engine.sv
// Top-of-book strategy engine: detects book changes, evaluates queue imbalance
// under spread/position/rate limits and emits one order at a time.
module tob_strategy_engine #(
   parameter int unsigned ORDER_QTY       = 100,
   parameter int unsigned MAX_SPREAD      = 10,
   parameter int          POS_LIMIT       = 1000,
   parameter int unsigned COOLDOWN_CYCLES = 16,
   parameter int unsigned IMB_SHIFT       = 1
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] best_bid_price,
   input  logic [31:0] best_bid_qty,
   input  logic [31:0] best_ask_price,
   input  logic [31:0] best_ask_qty,
   input  logic        tob_valid,
   output logic        order_valid,
   input  logic        order_ready,
   output logic [7:0]  order_side,
   output logic [31:0] order_price,
   output logic [31:0] order_qty,
   output logic [31:0] position,
   output logic [31:0] order_count,
   output logic [31:0] reject_count
);

   localparam int unsigned CMP_W = 33 + IMB_SHIFT;
   localparam logic [7:0]  SIDE_BUY  = 8'h01;
   localparam logic [7:0]  SIDE_SELL = 8'h02;
   localparam logic [31:0] QTY_NOM   = 32'(ORDER_QTY);
   localparam logic [31:0] SPREAD_MAX = 32'(MAX_SPREAD);
   localparam logic [31:0] CD_LOAD   = 32'(COOLDOWN_CYCLES) - 32'd1;
   localparam bit          HAS_CD    = (COOLDOWN_CYCLES != 0);
   localparam logic signed [33:0] LIM_POS = 34'(POS_LIMIT);
   localparam logic signed [33:0] LIM_NEG = -LIM_POS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_SEND,
      ST_COOLDOWN
   } state_t;

   state_t state, state_next;

   logic [31:0] snap_bid_p, snap_bid_q, snap_ask_p, snap_ask_q;
   logic [31:0] cd_cnt;

   logic              change_c;
   logic              book_ok_c;
   logic [CMP_W-1:0]  bid_ext_c, ask_ext_c, bid_sh_c, ask_sh_c;
   logic              buy_c, sell_c, signal_c;
   logic [31:0]       qty_c;
   logic signed [33:0] pos_ext_c, qty_ext_c, pos_buy_c, pos_sell_c;
   logic              pos_ok_c;
   logic              accept_c;
   logic              reject_c;
   logic              handshake_c;

   // Change detection against the snapshot, and signal evaluation on the snapshot
   always_comb begin
      change_c = tob_valid &&
                 ((best_bid_price != snap_bid_p) || (best_bid_qty != snap_bid_q) ||
                  (best_ask_price != snap_ask_p) || (best_ask_qty != snap_ask_q));

      book_ok_c = (snap_bid_q != 32'd0) && (snap_ask_q != 32'd0) &&
                  (snap_ask_p > snap_bid_p) &&
                  ((snap_ask_p - snap_bid_p) <= SPREAD_MAX);

      bid_ext_c = CMP_W'(snap_bid_q);
      ask_ext_c = CMP_W'(snap_ask_q);
      bid_sh_c  = bid_ext_c << IMB_SHIFT;
      ask_sh_c  = ask_ext_c << IMB_SHIFT;

      buy_c    = book_ok_c && (bid_ext_c > ask_sh_c);
      sell_c   = book_ok_c && !buy_c && (ask_ext_c > bid_sh_c);
      signal_c = buy_c || sell_c;

      if (buy_c) qty_c = (snap_ask_q < QTY_NOM) ? snap_ask_q : QTY_NOM;
      else       qty_c = (snap_bid_q < QTY_NOM) ? snap_bid_q : QTY_NOM;

      pos_ext_c  = {{2{position[31]}}, position};
      qty_ext_c  = {2'b00, qty_c};
      pos_buy_c  = pos_ext_c + qty_ext_c;
      pos_sell_c = pos_ext_c - qty_ext_c;
      pos_ok_c   = buy_c ? (pos_buy_c <= LIM_POS) : (pos_sell_c >= LIM_NEG);

      accept_c    = (state == ST_EVAL) && signal_c && pos_ok_c;
      reject_c    = (state == ST_EVAL) && signal_c && !pos_ok_c;
      handshake_c = (state == ST_SEND) && order_valid && order_ready;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (change_c && enable) state_next = ST_EVAL;
         ST_EVAL:     state_next = accept_c ? ST_SEND : ST_IDLE;
         ST_SEND:     if (handshake_c) state_next = HAS_CD ? ST_COOLDOWN : ST_IDLE;
         ST_COOLDOWN: if (cd_cnt == 32'd0) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_sys) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Snapshot capture on a change seen in IDLE, regardless of enable
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         snap_bid_p <= '0;
         snap_bid_q <= '0;
         snap_ask_p <= '0;
         snap_ask_q <= '0;
      end else if ((state == ST_IDLE) && change_c) begin
         snap_bid_p <= best_bid_price;
         snap_bid_q <= best_bid_qty;
         snap_ask_p <= best_ask_price;
         snap_ask_q <= best_ask_qty;
      end
   end

   // Order payload and valid; valid rises one cycle into SEND, drops on handshake
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         order_valid <= 1'b0;
         order_side  <= '0;
         order_price <= '0;
         order_qty   <= '0;
      end else begin
         if (accept_c) begin
            order_side  <= buy_c ? SIDE_BUY : SIDE_SELL;
            order_price <= buy_c ? snap_ask_p : snap_bid_p;
            order_qty   <= qty_c;
         end
         order_valid <= (state == ST_SEND) && !handshake_c;
      end
   end

   // Position and statistics counters
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         position     <= '0;
         order_count  <= '0;
         reject_count <= '0;
      end else begin
         if (handshake_c) begin
            order_count <= order_count + 32'd1;
            position    <= (order_side == SIDE_BUY) ? position + order_qty
                                                    : position - order_qty;
         end
         if (reject_c) reject_count <= reject_count + 32'd1;
      end
   end

   // Cooldown counter: loads on handshake, counts down to zero
   always_ff @(posedge clk_sys) begin
      if (rst)                                     cd_cnt <= '0;
      else if (handshake_c && HAS_CD)              cd_cnt <= CD_LOAD;
      else if ((state == ST_COOLDOWN) && (cd_cnt != 32'd0)) cd_cnt <= cd_cnt - 32'd1;
   end

endmodule

// File: tb/tb_tob_strategy_engine.sv
// Directed self-checking bench for tob_strategy_engine (POS_LIMIT reduced to 150).
module tb_tob_strategy_engine;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] best_bid_price, best_bid_qty, best_ask_price, best_ask_qty;
   logic        tob_valid;
   logic        order_valid;
   logic        order_ready;
   logic [7:0]  order_side;
   logic [31:0] order_price, order_qty, position, order_count, reject_count;

   int n_assert = 0;
   int n_fail   = 0;

   tob_strategy_engine #(
      .ORDER_QTY(100), .MAX_SPREAD(10), .POS_LIMIT(150),
      .COOLDOWN_CYCLES(16), .IMB_SHIFT(1)
   ) dut (
      .clk_sys(clk_sys), .rst(rst), .enable(enable),
      .best_bid_price(best_bid_price), .best_bid_qty(best_bid_qty),
      .best_ask_price(best_ask_price), .best_ask_qty(best_ask_qty),
      .tob_valid(tob_valid), .order_valid(order_valid), .order_ready(order_ready),
      .order_side(order_side), .order_price(order_price), .order_qty(order_qty),
      .position(position), .order_count(order_count), .reject_count(reject_count)
   );

   // 100 MHz clock
   always #5 clk_sys = ~clk_sys;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_book(input logic [31:0] bp, input logic [31:0] bq,
                           input logic [31:0] ap, input logic [31:0] aq);
      best_bid_price = bp;
      best_bid_qty   = bq;
      best_ask_price = ap;
      best_ask_qty   = aq;
   endtask

   // Runs n cycles and requires that order_valid never rises
   task automatic watch_none(input string tag, input int n);
      int hits;
      hits = 0;
      repeat (n) begin
         tick(1);
         if (order_valid) hits++;
      end
      chk(tag, 32'(hits), 32'd0);
   endtask

   initial begin
      int hits;
      rst = 1'b1; enable = 1'b1; tob_valid = 1'b0; order_ready = 1'b1;
      set_book(0, 0, 0, 0);

      // Reset state
      tick(2);
      rst = 1'b0;
      chk("rst_valid",  32'(order_valid), 32'd0);
      chk("rst_side",   32'(order_side),  32'd0);
      chk("rst_price",  order_price,      32'd0);
      chk("rst_qty",    order_qty,        32'd0);
      chk("rst_pos",    position,         32'd0);
      chk("rst_ocnt",   order_count,      32'd0);
      chk("rst_rcnt",   reject_count,     32'd0);

      // BUY 1005 x 100 with ready held high
      tob_valid = 1'b1;
      set_book(1000, 300, 1005, 100);
      tick(2);
      chk("buy_lat_early", 32'(order_valid), 32'd0);
      tick(1);
      chk("buy_valid", 32'(order_valid), 32'd1);
      chk("buy_side",  32'(order_side),  32'h01);
      chk("buy_price", order_price,      32'd1005);
      chk("buy_qty",   order_qty,        32'd100);
      tick(1);
      chk("buy_hs_valid", 32'(order_valid), 32'd0);
      chk("buy_hs_pos",   position,         32'd100);
      chk("buy_hs_ocnt",  order_count,      32'd1);

      // Second BUY during cooldown exceeds the 150 limit once evaluated
      set_book(1000, 301, 1005, 100);
      watch_none("lim_cooldown_quiet", 17);
      chk("lim_rcnt_before", reject_count, 32'd0);
      tick(1);
      chk("lim_rcnt_after", reject_count, 32'd1);
      watch_none("lim_no_order", 5);
      chk("lim_pos", position, 32'd100);
      chk("lim_ocnt", order_count, 32'd1);

      // SELL 1000 x 50 held by backpressure for 10 cycles
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      chk("rst2_pos", position, 32'd0);
      order_ready = 1'b0;
      set_book(1000, 50, 1002, 200);
      tick(2);
      chk("sell_lat_early", 32'(order_valid), 32'd0);
      tick(1);
      chk("sell_valid", 32'(order_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("sell_hold_valid", 32'(order_valid), 32'd1);
         chk("sell_hold_side",  32'(order_side),  32'h02);
         chk("sell_hold_price", order_price,      32'd1000);
         chk("sell_hold_qty",   order_qty,        32'd50);
      end
      chk("sell_hold_ocnt", order_count, 32'd0);
      order_ready = 1'b1;
      tick(1);
      chk("sell_hs_valid", 32'(order_valid), 32'd0);
      chk("sell_hs_pos",   position,         32'hFFFF_FFCE);
      chk("sell_hs_ocnt",  order_count,      32'd1);

      // Book churns every cycle of cooldown; the latest book is traded at H+19
      hits = 0;
      for (int i = 0; i < 16; i++) begin
         set_book(32'(1000 + i), 50, 32'(1002 + i), 200);
         tick(1);
         if (order_valid) hits++;
      end
      chk("cd_quiet", 32'(hits), 32'd0);
      set_book(990, 20, 995, 80);
      tick(2);
      chk("cd_h18_valid", 32'(order_valid), 32'd0);
      tick(1);
      chk("cd_h19_valid", 32'(order_valid), 32'd1);
      chk("cd_side",  32'(order_side), 32'h02);
      chk("cd_price", order_price,     32'd990);
      chk("cd_qty",   order_qty,       32'd20);
      tick(1);
      chk("cd_pos",  position,    32'hFFFF_FFBA);
      chk("cd_ocnt", order_count, 32'd2);
      tick(20);

      // Books that must not trade
      tob_valid = 1'b0;
      set_book(1000, 300, 1003, 100);
      watch_none("no_tob_valid", 6);
      tob_valid = 1'b1;
      set_book(1005, 300, 1000, 100);
      watch_none("no_crossed", 6);
      set_book(1000, 300, 1000, 100);
      watch_none("no_locked", 6);
      set_book(1000, 0, 1005, 100);
      watch_none("no_bidq_zero", 6);
      set_book(1000, 300, 1005, 0);
      watch_none("no_askq_zero", 6);
      set_book(1000, 200, 1005, 100);
      watch_none("no_imb_equal", 6);
      set_book(1000, 300, 1011, 100);
      watch_none("no_spread11", 6);
      enable = 1'b0;
      set_book(1000, 300, 1004, 100);
      watch_none("no_disabled", 6);
      enable = 1'b1;
      watch_none("no_stale_after_enable", 6);
      chk("no_rcnt", reject_count, 32'd0);
      chk("no_ocnt", order_count,  32'd2);

      // Spread exactly at the limit trades
      set_book(1000, 300, 1010, 100);
      tick(3);
      chk("sp10_valid", 32'(order_valid), 32'd1);
      chk("sp10_price", order_price,      32'd1010);
      tick(1);
      chk("sp10_pos",  position,    32'd30);
      chk("sp10_ocnt", order_count, 32'd3);
      tick(20);

      // Reset while an order is pending
      order_ready = 1'b0;
      set_book(1000, 50, 1002, 200);
      tick(3);
      chk("rs_pending_valid", 32'(order_valid), 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rs_valid", 32'(order_valid), 32'd0);
      chk("rs_pos",   position,         32'd0);
      chk("rs_ocnt",  order_count,      32'd0);
      chk("rs_rcnt",  reject_count,     32'd0);
      chk("rs_price", order_price,      32'd0);
      tick(2);
      chk("rs_fresh_early", 32'(order_valid), 32'd0);
      tick(1);
      chk("rs_fresh_valid", 32'(order_valid), 32'd1);
      chk("rs_fresh_side",  32'(order_side),  32'h02);
      chk("rs_fresh_price", order_price,      32'd1000);
      chk("rs_fresh_qty",   order_qty,        32'd50);
      order_ready = 1'b1;
      tick(1);
      chk("rs_fresh_pos",  position,    32'hFFFF_FFCE);
      chk("rs_fresh_ocnt", order_count, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
